// File: rtl/register_bank_if.sv
// Bus bundle between the reaction-time history bank and its display/compare clients.
interface register_bank_if #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic             WriteEn;
    logic [AW-1:0]    WriteAddr;
    logic [WIDTH-1:0] WriteData;
    logic             ClearReq;
    logic [AW-1:0]    RdAddrA;
    logic [WIDTH-1:0] RdDataA;
    logic             RdValidA;
    logic [AW-1:0]    RdAddrB;
    logic [WIDTH-1:0] RdDataB;
    logic             RdValidB;
    logic             Busy;
    logic [DEPTH-1:0] ValidMask;

    modport master (
        output WriteEn, WriteAddr, WriteData, ClearReq, RdAddrA, RdAddrB,
        input  RdDataA, RdValidA, RdDataB, RdValidB, Busy, ValidMask
    );

    modport slave (
        input  WriteEn, WriteAddr, WriteData, ClearReq, RdAddrA, RdAddrB,
        output RdDataA, RdValidA, RdDataB, RdValidB, Busy, ValidMask
    );
endinterface

// File: rtl/register_bank.sv
// DEPTH x WIDTH history bank: one write port, two registered read ports,
// per-row valid bits and a one-row-per-cycle clear sweep.
//   state    | meaning
//   IDLE     | writes accepted, ClearReq sampled
//   CLEARING | row[ptr] zeroed each cycle, writes and ClearReq ignored
module register_bank #(
    parameter int WIDTH  = 13,
    parameter int DEPTH  = 8,
    parameter bit BYPASS = 1'b1
) (
    input  logic            Clock,
    input  logic            Reset,
    register_bank_if.slave  bus
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH-1);

    typedef enum logic {IDLE, CLEARING} state_t;

    state_t           state, state_nxt;
    logic [AW-1:0]    ptr, ptr_nxt;
    logic             clr_en;
    logic             busy;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] valid_mask;

    logic             wr_ok;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    raddr_a, raddr_b;
    logic [WIDTH:0]   rd_a_nxt, rd_b_nxt;
    logic [WIDTH:0]   rd_a, rd_b;

    assign waddr   = bus.WriteAddr;
    assign wdata   = bus.WriteData;
    assign raddr_a = bus.RdAddrA;
    assign raddr_b = bus.RdAddrB;
    assign wr_ok   = (state == IDLE) && bus.WriteEn && ({1'b0, waddr} < DEPTH_W);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        clr_en    = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ClearReq) begin
                    state_nxt = CLEARING;
                    ptr_nxt   = '0;
                end
            end
            CLEARING: begin
                busy   = 1'b1;
                clr_en = 1'b1;
                if (ptr == LAST) begin
                    state_nxt = IDLE;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + AW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Returns {valid, data}; out-of-range rows read as empty.
    function automatic logic [WIDTH:0] read_row(input logic [AW-1:0] a);
        logic [WIDTH:0] r;
        r = '0;
        if ({1'b0, a} < DEPTH_W) begin
            if (BYPASS && wr_ok && (waddr == a))
                r = {1'b1, wdata};
            else
                r = {valid_mask[a], mem[a]};
        end
        return r;
    endfunction

    always_comb begin
        rd_a_nxt = read_row(raddr_a);
        rd_b_nxt = read_row(raddr_b);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            valid_mask <= '0;
            rd_a       <= '0;
            rd_b       <= '0;
        end else begin
            if (wr_ok) begin
                mem[waddr]        <= wdata;
                valid_mask[waddr] <= 1'b1;
            end else if (clr_en) begin
                mem[ptr]          <= '0;
                valid_mask[ptr]   <= 1'b0;
            end
            rd_a <= rd_a_nxt;
            rd_b <= rd_b_nxt;
        end
    end

    assign bus.RdDataA   = rd_a[WIDTH-1:0];
    assign bus.RdValidA  = rd_a[WIDTH];
    assign bus.RdDataB   = rd_b[WIDTH-1:0];
    assign bus.RdValidB  = rd_b[WIDTH];
    assign bus.Busy      = busy;
    assign bus.ValidMask = valid_mask;
endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: main 8-row bypass instance driven from vector records,
// plus a non-bypass instance and a 6-row instance exercised by short sequences.
module tb_register_bank;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    register_bank_if #(.WIDTH(13), .DEPTH(8)) bus_a ();
    register_bank_if #(.WIDTH(13), .DEPTH(8)) bus_b ();
    register_bank_if #(.WIDTH(13), .DEPTH(6)) bus_c ();

    register_bank #(.WIDTH(13), .DEPTH(8), .BYPASS(1'b1)) dut_a (.Clock(Clock), .Reset(Reset), .bus(bus_a));
    register_bank #(.WIDTH(13), .DEPTH(8), .BYPASS(1'b0)) dut_b (.Clock(Clock), .Reset(Reset), .bus(bus_b));
    register_bank #(.WIDTH(13), .DEPTH(6), .BYPASS(1'b1)) dut_c (.Clock(Clock), .Reset(Reset), .bus(bus_c));

    typedef struct {
        logic        rst;
        logic        we;
        logic [2:0]  wa;
        logic [12:0] wd;
        logic        clr;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [12:0] da;
        logic        va;
        logic [12:0] db;
        logic        vb;
        logic [7:0]  mask;
        logic        busy;
    } vec_t;

    vec_t sb_q[$];
    vec_t tbl[8];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mkv(input logic rst, input logic we, input logic [2:0] wa,
                                 input logic [12:0] wd, input logic clr, input logic [2:0] ra,
                                 input logic [2:0] rb, input logic [12:0] da, input logic va,
                                 input logic [12:0] db, input logic vb, input logic [7:0] mask,
                                 input logic busy);
        vec_t v;
        v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.clr = clr; v.ra = ra; v.rb = rb;
        v.da = da; v.va = va; v.db = db; v.vb = vb; v.mask = mask; v.busy = busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    // Drive one vector, queue its expectation, compare once the edge has produced output.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        Reset             = v.rst;
        bus_a.WriteEn     = v.we;
        bus_a.WriteAddr   = v.wa;
        bus_a.WriteData   = v.wd;
        bus_a.ClearReq    = v.clr;
        bus_a.RdAddrA     = v.ra;
        bus_a.RdAddrB     = v.rb;
        sb_q.push_back(v);
        tick();
        e = sb_q.pop_front();
        chk({tag, ".da"},   32'(bus_a.RdDataA),   32'(e.da));
        chk({tag, ".va"},   32'(bus_a.RdValidA),  32'(e.va));
        chk({tag, ".db"},   32'(bus_a.RdDataB),   32'(e.db));
        chk({tag, ".vb"},   32'(bus_a.RdValidB),  32'(e.vb));
        chk({tag, ".mask"}, 32'(bus_a.ValidMask), 32'(e.mask));
        chk({tag, ".busy"}, 32'(bus_a.Busy),      32'(e.busy));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [7:0] mask_exp;
        int         n;

        {bus_a.WriteEn, bus_a.WriteAddr, bus_a.WriteData, bus_a.ClearReq, bus_a.RdAddrA, bus_a.RdAddrB} = '0;
        {bus_b.WriteEn, bus_b.WriteAddr, bus_b.WriteData, bus_b.ClearReq, bus_b.RdAddrA, bus_b.RdAddrB} = '0;
        {bus_c.WriteEn, bus_c.WriteAddr, bus_c.WriteData, bus_c.ClearReq, bus_c.RdAddrA, bus_c.RdAddrB} = '0;

        tbl[0] = mkv(1'b0, 1'b1, 3'd3, 13'h1ABC, 1'b0, 3'd0, 3'd0, 13'h0000, 1'b0, 13'h0000, 1'b0, 8'h08, 1'b0);
        tbl[1] = mkv(1'b0, 1'b0, 3'd0, 13'h0000, 1'b0, 3'd3, 3'd3, 13'h1ABC, 1'b1, 13'h1ABC, 1'b1, 8'h08, 1'b0);
        tbl[2] = mkv(1'b0, 1'b1, 3'd5, 13'h0055, 1'b0, 3'd3, 3'd5, 13'h1ABC, 1'b1, 13'h0055, 1'b1, 8'h28, 1'b0);
        tbl[3] = mkv(1'b0, 1'b0, 3'd0, 13'h0000, 1'b0, 3'd5, 3'd0, 13'h0055, 1'b1, 13'h0000, 1'b0, 8'h28, 1'b0);
        tbl[4] = mkv(1'b0, 1'b1, 3'd3, 13'h0FFF, 1'b0, 3'd3, 3'd3, 13'h0FFF, 1'b1, 13'h0FFF, 1'b1, 8'h28, 1'b0);
        tbl[5] = mkv(1'b0, 1'b1, 3'd0, 13'h1FFF, 1'b0, 3'd3, 3'd0, 13'h0FFF, 1'b1, 13'h1FFF, 1'b1, 8'h29, 1'b0);
        tbl[6] = mkv(1'b0, 1'b1, 3'd7, 13'h0001, 1'b0, 3'd7, 3'd6, 13'h0001, 1'b1, 13'h0000, 1'b0, 8'hA9, 1'b0);
        tbl[7] = mkv(1'b0, 1'b0, 3'd0, 13'h0000, 1'b0, 3'd0, 3'd7, 13'h1FFF, 1'b1, 13'h0001, 1'b1, 8'hA9, 1'b0);

        // Reset held two cycles with every other input active.
        for (int i = 0; i < 2; i++)
            apply(mkv(1'b1, 1'b1, 3'd3, 13'h1FFF, 1'b1, 3'd3, 3'd3, 13'h0, 1'b0, 13'h0, 1'b0, 8'h00, 1'b0),
                  $sformatf("rst%0d", i));

        for (int i = 0; i < 8; i++) apply(tbl[i], $sformatf("t%0d", i));

        // Fill every row with 0x100+i.
        mask_exp = 8'hA9;
        for (int i = 0; i < 8; i++) begin
            mask_exp = mask_exp | 8'(32'h1 << i);
            apply(mkv(1'b0, 1'b1, 3'(i), 13'(32'h100 + i), 1'b0, 3'(i), 3'd7,
                      13'(32'h100 + i), 1'b1, (i == 7) ? 13'h107 : 13'h001, 1'b1, mask_exp, 1'b0),
                  $sformatf("fill%0d", i));
        end

        // Clear request together with a write to row 2: write lands, sweep erases it.
        apply(mkv(1'b0, 1'b1, 3'd2, 13'h0123, 1'b1, 3'd7, 3'd2, 13'h107, 1'b1, 13'h0123, 1'b1, 8'hFF, 1'b1), "clr");
        for (int k = 0; k < 8; k++)
            apply(mkv(1'b0, 1'b1, 3'd7, 13'h0AAA, (k > 0), 3'd7, (k == 0) ? 3'd0 : 3'(k - 1),
                      13'h107, 1'b1, (k == 0) ? 13'h100 : 13'h000, (k == 0),
                      8'((32'hFF << (k + 1)) & 32'hFF), (k < 7)),
                  $sformatf("sw%0d", k));
        apply(mkv(1'b0, 1'b0, 3'd0, 13'h0, 1'b0, 3'd7, 3'd2, 13'h0, 1'b0, 13'h0, 1'b0, 8'h00, 1'b0), "swend");

        // Reset on the third Busy cycle.
        apply(mkv(1'b0, 1'b1, 3'd1, 13'h0011, 1'b0, 3'd1, 3'd0, 13'h011, 1'b1, 13'h0, 1'b0, 8'h02, 1'b0), "mr0");
        apply(mkv(1'b0, 1'b0, 3'd0, 13'h0000, 1'b1, 3'd1, 3'd0, 13'h011, 1'b1, 13'h0, 1'b0, 8'h02, 1'b1), "mr1");
        apply(mkv(1'b0, 1'b0, 3'd0, 13'h0000, 1'b0, 3'd1, 3'd1, 13'h011, 1'b1, 13'h011, 1'b1, 8'h02, 1'b1), "mr2");
        apply(mkv(1'b0, 1'b0, 3'd0, 13'h0000, 1'b0, 3'd1, 3'd0, 13'h011, 1'b1, 13'h0, 1'b0, 8'h00, 1'b1), "mr3");
        apply(mkv(1'b1, 1'b1, 3'd3, 13'h0333, 1'b0, 3'd1, 3'd3, 13'h0, 1'b0, 13'h0, 1'b0, 8'h00, 1'b0), "mr4");
        apply(mkv(1'b0, 1'b1, 3'd4, 13'h0444, 1'b0, 3'd4, 3'd1, 13'h444, 1'b1, 13'h0, 1'b0, 8'h10, 1'b0), "mr5");
        apply(mkv(1'b0, 1'b0, 3'd0, 13'h0000, 1'b0, 3'd1, 3'd4, 13'h0, 1'b0, 13'h444, 1'b1, 8'h10, 1'b0), "mr6");

        // Non-bypass instance: same-cycle read returns the pre-write row.
        bus_b.WriteEn = 1'b1; bus_b.WriteAddr = 3'd5; bus_b.WriteData = 13'h0055;
        bus_b.RdAddrA = 3'd5; bus_b.RdAddrB = 3'd5;
        tick();
        chk("b_byp.db", 32'(bus_b.RdDataB), 32'h0);
        chk("b_byp.vb", 32'(bus_b.RdValidB), 32'h0);
        chk("b_byp.da", 32'(bus_b.RdDataA), 32'h0);
        bus_b.WriteEn = 1'b0;
        tick();
        chk("b_rd.db", 32'(bus_b.RdDataB), 32'h55);
        chk("b_rd.vb", 32'(bus_b.RdValidB), 32'h1);
        chk("b_rd.mask", 32'(bus_b.ValidMask), 32'h20);
        bus_b.WriteEn = 1'b1; bus_b.WriteData = 13'h0AAA;
        tick();
        chk("b_old.db", 32'(bus_b.RdDataB), 32'h55);
        chk("b_old.vb", 32'(bus_b.RdValidB), 32'h1);
        bus_b.WriteEn = 1'b0;
        tick();
        chk("b_new.da", 32'(bus_b.RdDataA), 32'hAAA);

        // Six-row instance: out-of-range addresses and a non-power-of-two sweep.
        bus_c.WriteEn = 1'b1; bus_c.WriteAddr = 3'd2; bus_c.WriteData = 13'h0222; bus_c.RdAddrA = 3'd2;
        tick();
        chk("c_wr.da", 32'(bus_c.RdDataA), 32'h222);
        chk("c_wr.mask", 32'(bus_c.ValidMask), 32'h04);
        bus_c.WriteAddr = 3'd7; bus_c.WriteData = 13'h1111; bus_c.RdAddrA = 3'd7; bus_c.RdAddrB = 3'd2;
        tick();
        chk("c_oor7.da", 32'(bus_c.RdDataA), 32'h0);
        chk("c_oor7.va", 32'(bus_c.RdValidA), 32'h0);
        chk("c_oor7.db", 32'(bus_c.RdDataB), 32'h222);
        chk("c_oor7.mask", 32'(bus_c.ValidMask), 32'h04);
        bus_c.WriteAddr = 3'd6; bus_c.RdAddrA = 3'd6;
        tick();
        chk("c_oor6.da", 32'(bus_c.RdDataA), 32'h0);
        chk("c_oor6.va", 32'(bus_c.RdValidA), 32'h0);
        chk("c_oor6.mask", 32'(bus_c.ValidMask), 32'h04);
        bus_c.WriteEn = 1'b0; bus_c.ClearReq = 1'b1;
        tick();
        bus_c.ClearReq = 1'b0;
        n = 0;
        while (bus_c.Busy && n < 20) begin
            n++;
            tick();
        end
        chk("c_busy_len", 32'(n), 32'd6);
        chk("c_clr.mask", 32'(bus_c.ValidMask), 32'h0);
        tick();
        chk("c_clr.db", 32'(bus_c.RdDataB), 32'h0);
        chk("c_clr.vb", 32'(bus_c.RdValidB), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
